// File: rtl/riscv_mem_pkg.sv
// Shared constants and types for the RISC-V memory responder.
package riscv_mem_pkg;

  localparam int unsigned C_DATA_WIDTH      = 32;
  localparam int unsigned C_IMEM_ADDR_WIDTH = 9;
  localparam int unsigned C_DMEM_ADDR_WIDTH = 8;
  localparam int unsigned C_STORE_CNT_WIDTH = 16;

  localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } mem_state_e;

endpackage

// File: rtl/riscv_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered write-first read port
// with a synchronous clear of the read register.
module riscv_sdp_ram #(
  parameter int unsigned             P_WIDTH      = 32,
  parameter int unsigned             P_ADDR_WIDTH = 8,
  parameter logic [P_WIDTH-1:0]      P_CLR_VAL    = '0
) (
  input  logic                    clk,
  input  logic                    i_rd_clr,
  input  logic                    i_we,
  input  logic [P_ADDR_WIDTH-1:0] i_waddr,
  input  logic [P_WIDTH-1:0]      i_wdata,
  input  logic [P_ADDR_WIDTH-1:0] i_raddr,
  output logic [P_WIDTH-1:0]      o_rdata
);

  localparam int unsigned C_DEPTH = 2 ** P_ADDR_WIDTH;

  logic [P_WIDTH-1:0] r_mem [C_DEPTH];
  logic [P_WIDTH-1:0] r_rdata;

  // Array contents survive the clear; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_rd_clr)                         r_rdata <= P_CLR_VAL;
    else if (i_we && i_waddr == i_raddr)  r_rdata <= i_wdata;
    else                                  r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/riscv_mem_responder.sv
// IMEM/DMEM responder for the RISC-V core with a saturating store counter.
// Define RISCV_MEM_TOHOST_EN to enable the tohost decode and RUN/HALTED FSM.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned                 P_DATA_WIDTH      = C_DATA_WIDTH,
  parameter int unsigned                 P_IMEM_ADDR_WIDTH = C_IMEM_ADDR_WIDTH,
  parameter int unsigned                 P_DMEM_ADDR_WIDTH = C_DMEM_ADDR_WIDTH,
  parameter logic [P_DMEM_ADDR_WIDTH-1:0] P_TOHOST_ADDR    = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [P_IMEM_ADDR_WIDTH-1:0] inst_addr,
  output logic [P_DATA_WIDTH-1:0]      instr_data,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] data_addr,
  input  logic [P_DATA_WIDTH-1:0]      data_wr,
  input  logic                         data_wr_en_ma,
  output logic [P_DATA_WIDTH-1:0]      data_rd,
  input  logic                         imem_ld_en,
  input  logic [P_IMEM_ADDR_WIDTH-1:0] imem_ld_addr,
  input  logic [P_DATA_WIDTH-1:0]      imem_ld_data,
  output logic [C_STORE_CNT_WIDTH-1:0] store_cnt,
  output logic                         done,
  output logic [P_DATA_WIDTH-1:0]      tohost_val
);

  logic                         w_store_ok;
  logic                         w_dmem_we;
  logic [C_STORE_CNT_WIDTH-1:0] r_store_cnt;

  // Program load stays live during reset so the core can be held while loading.
  riscv_sdp_ram #(
    .P_WIDTH      (P_DATA_WIDTH),
    .P_ADDR_WIDTH (P_IMEM_ADDR_WIDTH),
    .P_CLR_VAL    (P_DATA_WIDTH'(C_NOP_INSTR))
  ) u_imem (
    .clk      (clk),
    .i_rd_clr (reset),
    .i_we     (imem_ld_en),
    .i_waddr  (imem_ld_addr),
    .i_wdata  (imem_ld_data),
    .i_raddr  (inst_addr),
    .o_rdata  (instr_data)
  );

  riscv_sdp_ram #(
    .P_WIDTH      (P_DATA_WIDTH),
    .P_ADDR_WIDTH (P_DMEM_ADDR_WIDTH),
    .P_CLR_VAL    ('0)
  ) u_dmem (
    .clk      (clk),
    .i_rd_clr (reset),
    .i_we     (w_dmem_we),
    .i_waddr  (data_addr),
    .i_wdata  (data_wr),
    .i_raddr  (data_addr),
    .o_rdata  (data_rd)
  );

`ifdef RISCV_MEM_TOHOST_EN
  mem_state_e              r_state;
  mem_state_e              w_state_nxt;
  logic                    r_done;
  logic                    w_done_nxt;
  logic [P_DATA_WIDTH-1:0] r_tohost_val;
  logic [P_DATA_WIDTH-1:0] w_tohost_val_nxt;

  // A tohost store halts the responder instead of reaching DMEM.
  always_comb begin
    w_state_nxt      = r_state;
    w_done_nxt       = r_done;
    w_tohost_val_nxt = r_tohost_val;
    w_store_ok       = 1'b0;
    case (r_state)
      RUN: begin
        if (data_wr_en_ma) begin
          if (data_addr == P_TOHOST_ADDR) begin
            w_state_nxt      = HALTED;
            w_done_nxt       = 1'b1;
            w_tohost_val_nxt = data_wr;
          end else begin
            w_store_ok = 1'b1;
          end
        end
      end
      HALTED: begin
        w_store_ok = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_done       <= 1'b0;
      r_tohost_val <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_done       <= w_done_nxt;
      r_tohost_val <= w_tohost_val_nxt;
    end
  end

  assign done       = r_done;
  assign tohost_val = r_tohost_val;
`else
  logic w_unused_tohost_addr;

  assign w_unused_tohost_addr = ^P_TOHOST_ADDR;
  assign w_store_ok           = data_wr_en_ma;
  assign done                 = 1'b0;
  assign tohost_val           = '0;
`endif

  assign w_dmem_we = w_store_ok && !reset;

  // Committed-store counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_store_cnt <= '0;
    end else if (w_dmem_we && (r_store_cnt != '1)) begin
      r_store_cnt <= r_store_cnt + C_STORE_CNT_WIDTH'(1);
    end
  end

  assign store_cnt = r_store_cnt;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed self-checking bench for riscv_mem_responder (both RISCV_MEM_TOHOST_EN builds).
module tb_riscv_mem_responder;

  logic        clk;
  logic        reset;
  logic [8:0]  inst_addr;
  logic [31:0] instr_data;
  logic [7:0]  data_addr;
  logic [31:0] data_wr;
  logic        data_wr_en_ma;
  logic [31:0] data_rd;
  logic        imem_ld_en;
  logic [8:0]  imem_ld_addr;
  logic [31:0] imem_ld_data;
  logic [15:0] store_cnt;
  logic        done;
  logic [31:0] tohost_val;

  int n_checks;
  int n_errors;

  riscv_mem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .inst_addr     (inst_addr),
    .instr_data    (instr_data),
    .data_addr     (data_addr),
    .data_wr       (data_wr),
    .data_wr_en_ma (data_wr_en_ma),
    .data_rd       (data_rd),
    .imem_ld_en    (imem_ld_en),
    .imem_ld_addr  (imem_ld_addr),
    .imem_ld_data  (imem_ld_data),
    .store_cnt     (store_cnt),
    .done          (done),
    .tohost_val    (tohost_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [7:0] addr, input logic [31:0] wdata);
    data_addr     = addr;
    data_wr       = wdata;
    data_wr_en_ma = 1'b1;
    tick();
    data_wr_en_ma = 1'b0;
  endtask

  logic [31:0] prog [4];

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    prog[0]       = 32'hA000_000A;
    prog[1]       = 32'hB000_000B;
    prog[2]       = 32'hC000_000C;
    prog[3]       = 32'hD000_000D;
    reset         = 1'b1;
    inst_addr     = '0;
    data_addr     = '0;
    data_wr       = '0;
    data_wr_en_ma = 1'b0;
    imem_ld_en    = 1'b0;
    imem_ld_addr  = '0;
    imem_ld_data  = '0;

    // Program load while held in reset
    for (int i = 0; i < 4; i++) begin
      imem_ld_en   = 1'b1;
      imem_ld_addr = 9'(i);
      imem_ld_data = prog[i];
      tick();
    end
    imem_ld_en = 1'b0;
    tick();
    check("rst_instr", instr_data, 32'h0000_0013);
    check("rst_data_rd", data_rd, 32'h0);
    check("rst_store_cnt", 32'(store_cnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_tohost_val", tohost_val, 32'h0);

    // Sequential fetch after release
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 9'(i);
      tick();
      check($sformatf("fetch_%0d", i), instr_data, prog[i]);
    end

    // IMEM write-first on the fetch address, then plain read-back
    inst_addr    = 9'h5;
    imem_ld_en   = 1'b1;
    imem_ld_addr = 9'h5;
    imem_ld_data = 32'h1234_5678;
    tick();
    check("imem_wr_first", instr_data, 32'h1234_5678);
    imem_ld_en = 1'b0;
    tick();
    check("imem_readback", instr_data, 32'h1234_5678);

    // DMEM store with same-edge load
    store(8'h10, 32'hDEAD_BEEF);
    check("dmem_wr_first", data_rd, 32'hDEAD_BEEF);
    check("store_cnt_1", 32'(store_cnt), 32'h1);
    tick();
    check("dmem_readback", data_rd, 32'hDEAD_BEEF);

    store(8'h11, 32'hCAFE_F00D);
    data_addr = 8'h10;
    tick();
    check("dmem_other_addr", data_rd, 32'hDEAD_BEEF);
    store(8'h20, 32'h1111_1111);
    check("store_cnt_3", 32'(store_cnt), 32'h3);

`ifdef RISCV_MEM_TOHOST_EN
    // tohost store halts; DMEM and counter untouched
    store(8'hFF, 32'h0000_0001);
    check("tohost_done", 32'(done), 32'h1);
    check("tohost_val", tohost_val, 32'h1);
    check("tohost_not_counted", 32'(store_cnt), 32'h3);
    check("tohost_not_written", 32'(data_rd == 32'h1), 32'h0);
    store(8'h20, 32'h2222_2222);
    check("halted_store_ignored", data_rd, 32'h1111_1111);
    check("halted_cnt_frozen", 32'(store_cnt), 32'h3);
    check("halted_done_held", 32'(done), 32'h1);
    inst_addr = 9'h2;
    tick();
    check("halted_fetch", instr_data, prog[2]);
`else
    // Without tohost, the top word is ordinary DMEM
    store(8'hFF, 32'h5A5A_5A5A);
    check("top_word_store", data_rd, 32'h5A5A_5A5A);
    check("top_word_counted", 32'(store_cnt), 32'h4);
    check("no_tohost_done", 32'(done), 32'h0);
    check("no_tohost_val", tohost_val, 32'h0);
`endif

    // Reset clears outputs but keeps memory contents
    reset = 1'b1;
    tick();
    check("rst2_done", 32'(done), 32'h0);
    check("rst2_data_rd", data_rd, 32'h0);
    check("rst2_instr", instr_data, 32'h0000_0013);
    check("rst2_store_cnt", 32'(store_cnt), 32'h0);
    reset     = 1'b0;
    data_addr = 8'h10;
    tick();
    check("dmem_retained", data_rd, 32'hDEAD_BEEF);
    data_addr = 8'h20;
    tick();
    check("dmem_retained_20", data_rd, 32'h1111_1111);

    // Counter saturation
    data_addr     = 8'h30;
    data_wr_en_ma = 1'b1;
    for (int i = 0; i < 32'hFFFE; i++) begin
      data_wr = 32'(i);
      tick();
    end
    data_wr_en_ma = 1'b0;
    check("cnt_fffe", 32'(store_cnt), 32'h0000_FFFE);
    check("cnt_last_store", data_rd, 32'h0000_FFFD);
    store(8'h31, 32'h1);
    check("cnt_ffff", 32'(store_cnt), 32'h0000_FFFF);
    store(8'h32, 32'h2);
    store(8'h33, 32'h3);
    check("cnt_sat", 32'(store_cnt), 32'h0000_FFFF);
    tick();
    check("cnt_sat_held", 32'(store_cnt), 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
